seg_scan_ctrl: RTL

Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Holds a double-buffered display value and walks one digit per slot, with a dead-time gap between digits to suppress ghosting.
- Presents the selected nibble and a blank flag to the downstream hex-to-cathode decoder, and drives the active-low anodes and decimal point.
- Sits between the system logic (load handshake) and the board display pins.

---
 rtl/seg_scan_ctrl_pkg.sv | 9 +
 rtl/seg_scan_ctrl_if.sv | 9 +
 rtl/seg_scan_ctrl_slot_timer.sv | 37 +++
 rtl/seg_scan_ctrl.sv | 89 ++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared types and width helpers for the 7-segment scan controller
package seg_pkg;
    typedef enum logic {BLANK, ON} state_t;
    localparam int HEX_W = 4;
    localparam logic [31:0] ANODE_OFF = '1;
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load handshake between system logic and the scan controller
interface seg_scan_ctrl_if #(parameter int NUM_DIGITS = 4) ();
    logic                      load_valid;
    logic                      load_ready;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic [NUM_DIGITS-1:0]     load_dp;
    modport master (output load_valid, load_data, load_dp, input load_ready);
    modport slave (input load_valid, load_data, load_dp, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl_slot_timer.sv
// seg_slot_timer: slot counter and digit index with blank-end, slot-end and frame-end strobes
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK_CYCLES = 16,
    localparam int CW = cnt_w(PRESCALE),
    localparam int IW = cnt_w(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx_nxt,
    output logic          cnt_blank_end,
    output logic          slot_end,
    output logic          frame_end
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    always_comb begin
        cnt_blank_end = cnt_q == CW'(BLANK_CYCLES - 1);
        slot_end = cnt_q == CW'(PRESCALE - 1);
        frame_end = slot_end && idx_q == IW'(NUM_DIGITS - 1);
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = frame_end ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end
    assign idx_nxt = idx_d;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered, dead-time multiplexed scan of a common-anode 7-segment display
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK_CYCLES = 16,
    localparam int IW = cnt_w(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_ctrl_if.slave        ld,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic                  lz_blank,
    output logic [HEX_W-1:0]      hex_out,
    output logic                  hex_blank,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  frame_done
);
    localparam int DW = HEX_W * NUM_DIGITS;
    state_t state_q, state_d;
    logic [DW-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d, anode_q, anode_d;
    logic pend_full_q, pend_full_d, hex_blank_q, hex_blank_d, dp_n_q, dp_n_d, frame_done_q, frame_done_d;
    logic [HEX_W-1:0] hex_q, hex_d, nib;
    logic [IW-1:0] idx_nxt;
    logic cnt_blank_end, slot_end, frame_end, commit, accept, nz, show;
    seg_slot_timer #(
        .NUM_DIGITS(NUM_DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk(clk), .rst(rst), .idx_nxt(idx_nxt),
        .cnt_blank_end(cnt_blank_end), .slot_end(slot_end), .frame_end(frame_end)
    );
    // Outputs are registered from next-cycle state so they line up with the slot they describe.
    always_comb begin
        state_d = cnt_blank_end ? ON : slot_end ? BLANK : state_q;
        commit = frame_end && pend_full_q;
        accept = ld.load_valid && !pend_full_q;
        act_data_d = commit ? pend_data_q : act_data_q;
        act_dp_d = commit ? pend_dp_q : act_dp_q;
        pend_data_d = accept ? ld.load_data : pend_data_q;
        pend_dp_d = accept ? ld.load_dp : pend_dp_q;
        pend_full_d = accept || (pend_full_q && !commit);
        nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            nz = nz | ((IW'(i) >= idx_nxt) && (act_data_d[i*HEX_W +: HEX_W] != '0));
        nib = act_data_d[idx_nxt*HEX_W +: HEX_W];
        show = state_d == ON && digit_en[idx_nxt] && !(lz_blank && idx_nxt != '0 && !nz);
        anode_d = show ? ~(NUM_DIGITS'(1) << idx_nxt) : ANODE_OFF[NUM_DIGITS-1:0];
        hex_d = show ? nib : '0;
        hex_blank_d = !show;
        dp_n_d = !(show && act_dp_d[idx_nxt]);
        frame_done_d = frame_end;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            act_data_q <= '0;
            act_dp_q <= '0;
            pend_data_q <= '0;
            pend_dp_q <= '0;
            pend_full_q <= 1'b0;
            anode_q <= ANODE_OFF[NUM_DIGITS-1:0];
            hex_q <= '0;
            hex_blank_q <= 1'b1;
            dp_n_q <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            act_data_q <= act_data_d;
            act_dp_q <= act_dp_d;
            pend_data_q <= pend_data_d;
            pend_dp_q <= pend_dp_d;
            pend_full_q <= pend_full_d;
            anode_q <= anode_d;
            hex_q <= hex_d;
            hex_blank_q <= hex_blank_d;
            dp_n_q <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end
    assign ld.load_ready = !pend_full_q;
    assign anode = anode_q;
    assign hex_out = hex_q;
    assign hex_blank = hex_blank_q;
    assign dp_n = dp_n_q;
    assign frame_done = frame_done_q;
endmodule
